// File: rtl/oven_pkg.sv
// Shared constants for the microwave oven controller: synchronizer depth and
// the safe levels that input synchronizers load while rst is held.
package oven_pkg;

   localparam int OVEN_SYNC_STAGES_DEFAULT = 2;

   // Safe levels: buttons released, door treated as open, timer not expired.
   localparam logic BTN_IDLE   = 1'b1;
   localparam logic DOOR_SAFE  = 1'b0;
   localparam logic TIMER_SAFE = 1'b0;

endpackage : oven_pkg

// File: rtl/oven_sync.sv
// Single-bit synchronizer of parameterised depth with a synchronous,
// active-high reset to a chosen level. STAGES = 0 passes the input straight through.
module oven_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   generate
      if (STAGES == 0) begin : g_bypass
         assign q = d;
      end else begin : g_chain
         logic [STAGES-1:0] chain;

         // NOTE: sequential state uses non-blocking assignments so every stage
         // samples the previous stage's old value, giving a true shift chain.
         always_ff @(posedge clk) begin
            if (rst) begin
               chain <= {STAGES{RST_VAL}};
            end else begin
               chain[0] <= d;
               for (int i = 1; i < STAGES; i++) begin
                  chain[i] <= chain[i-1];
               end
            end
         end

         assign q = chain[STAGES-1];
      end
   endgenerate

endmodule : oven_sync

// File: rtl/on_off_logic.sv
// Start/stop decision for the magnetron: synchronizes the operator and door
// inputs, registers set/reset commands and holds the on/off latch as mag_on.
module on_off_logic
   import oven_pkg::*;
#(
   parameter int SYNC_STAGES = OVEN_SYNC_STAGES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic startn,
   input  logic stopn,
   input  logic clrn,
   input  logic door_closed,
   input  logic timer_done,
   output logic set,
   output logic reset,
   output logic mag_on
);

   logic s_startn;
   logic s_stopn;
   logic s_clrn;
   logic s_door_closed;
   logic s_timer_done;
   logic set_c;
   logic reset_c;

   oven_sync #(.STAGES(SYNC_STAGES), .RST_VAL(BTN_IDLE)) u_sync_start (
      .clk (clk),
      .rst (rst),
      .d   (startn),
      .q   (s_startn)
   );

   oven_sync #(.STAGES(SYNC_STAGES), .RST_VAL(BTN_IDLE)) u_sync_stop (
      .clk (clk),
      .rst (rst),
      .d   (stopn),
      .q   (s_stopn)
   );

   oven_sync #(.STAGES(SYNC_STAGES), .RST_VAL(BTN_IDLE)) u_sync_clr (
      .clk (clk),
      .rst (rst),
      .d   (clrn),
      .q   (s_clrn)
   );

   oven_sync #(.STAGES(SYNC_STAGES), .RST_VAL(DOOR_SAFE)) u_sync_door (
      .clk (clk),
      .rst (rst),
      .d   (door_closed),
      .q   (s_door_closed)
   );

   oven_sync #(.STAGES(SYNC_STAGES), .RST_VAL(TIMER_SAFE)) u_sync_timer (
      .clk (clk),
      .rst (rst),
      .d   (timer_done),
      .q   (s_timer_done)
   );

   // An open door or expired timer must never produce a start request.
   always_comb begin
      set_c   = !s_startn && s_door_closed && !s_timer_done;
      reset_c = !s_door_closed || !s_clrn || !s_stopn || s_timer_done;
   end

   // Both commands are reported unmasked; only the latch gives reset priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         set    <= 1'b0;
         reset  <= 1'b1;
         mag_on <= 1'b0;
      end else begin
         set   <= set_c;
         reset <= reset_c;
         if (reset) begin
            mag_on <= 1'b0;
         end else if (set) begin
            mag_on <= 1'b1;
         end
      end
   end

endmodule : on_off_logic

// File: tb/tb_on_off_logic.sv
// Self-checking bench for on_off_logic: directed scenarios with literal
// expectations plus randomized stimulus compared every cycle to a history model.
module tb_on_off_logic;

   localparam int SYNC = 2;
   localparam int LAT  = SYNC + 1;
   localparam int MAXE = 8192;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic startn = 1'b1;
   logic stopn = 1'b1;
   logic clrn = 1'b1;
   logic door_closed = 1'b0;
   logic timer_done = 1'b0;
   logic set;
   logic reset;
   logic mag_on;

   int n_checks = 0;
   int n_errors = 0;

   on_off_logic #(.SYNC_STAGES(SYNC)) dut (
      .clk         (clk),
      .rst         (rst),
      .startn      (startn),
      .stopn       (stopn),
      .clrn        (clrn),
      .door_closed (door_closed),
      .timer_done  (timer_done),
      .set         (set),
      .reset       (reset),
      .mag_on      (mag_on)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic actual, input logic expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
      end
   endtask

   // Model: history of sampled inputs per edge; outputs after edge k follow
   // from the inputs sampled SYNC edges earlier, or safe levels if rst intervened.
   typedef struct packed {
      logic startn;
      logic stopn;
      logic clrn;
      logic door_closed;
      logic timer_done;
   } in_t;

   localparam in_t SAFE_IN = '{startn: 1'b1, stopn: 1'b1, clrn: 1'b1,
                               door_closed: 1'b0, timer_done: 1'b0};

   in_t in_hist [MAXE];
   int  edge_no  = 0;
   int  last_rst = -1;
   bit  exp_set, exp_reset, exp_mag;
   bit  model_valid = 0;

   always @(posedge clk) begin
      in_t v;
      int  m;
      edge_no++;
      in_hist[edge_no] = '{startn, stopn, clrn, door_closed, timer_done};
      if (rst) begin
         last_rst  = edge_no;
         exp_set   = 0;
         exp_reset = 1;
         exp_mag   = 0;
      end else if (last_rst > 0) begin
         if (exp_reset)    exp_mag = 0;
         else if (exp_set) exp_mag = 1;
         m = edge_no - SYNC;
         v = (m > last_rst) ? in_hist[m] : SAFE_IN;
         exp_set   = !v.startn && v.door_closed && !v.timer_done;
         exp_reset = !v.door_closed || !v.clrn || !v.stopn || v.timer_done;
      end
      model_valid = (last_rst > 0);
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check("model_set",    set,    exp_set);
         check("model_reset",  reset,  exp_reset);
         check("model_mag_on", mag_on, exp_mag);
      end
   end

   task automatic drive(input logic st, input logic sp, input logic cl,
                        input logic dc, input logic td);
      startn      = st;
      stopn       = sp;
      clrn        = cl;
      door_closed = dc;
      timer_done  = td;
   endtask

   task automatic step(input string name, input logic st, input logic sp, input logic cl,
                       input logic dc, input logic td,
                       input logic e_set, input logic e_reset, input logic e_mag);
      @(posedge clk);
      #1 drive(st, sp, cl, dc, td);
      repeat (LAT) @(posedge clk);
      @(negedge clk);
      check({name, "_set"},   set,   e_set);
      check({name, "_reset"}, reset, e_reset);
      @(negedge clk);
      check({name, "_mag_on"}, mag_on, e_mag);
   endtask

   initial begin
      // Reset for two edges, then check the reset state.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_set",    set,    1'b0);
      check("rst_reset",  reset,  1'b1);
      check("rst_mag_on", mag_on, 1'b0);
      rst = 1'b0;

      //     name          st  sp  cl  dc  td   set rst mag
      step("start",       0,  1,  1,  1,  0,   1,  0,  1);
      step("release",     1,  1,  1,  1,  0,   0,  0,  1);
      step("door_timer",  0,  1,  0,  0,  1,   0,  1,  0);
      step("start_stop",  0,  0,  1,  1,  0,   1,  1,  0);
      step("timer_done",  0,  1,  1,  1,  1,   0,  1,  0);
      step("clear",       1,  1,  0,  1,  0,   0,  1,  0);
      step("restart",     0,  1,  1,  1,  0,   1,  0,  1);
      step("idle_on",     1,  1,  1,  1,  0,   0,  0,  1);

      // Mid-operation reset with door closed and no buttons pressed.
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("midrst_set",    set,    1'b0);
      check("midrst_reset",  reset,  1'b1);
      check("midrst_mag_on", mag_on, 1'b0);
      repeat (SYNC) @(posedge clk);
      #1 check("midrst_reset_hold", reset, 1'b1);
      @(posedge clk);
      #1 check("midrst_reset_clear", reset, 1'b0);
      check("midrst_mag_stays", mag_on, 1'b0);
      @(posedge clk);
      #1 check("midrst_mag_later", mag_on, 1'b0);

      // Randomized segments; inputs held for a few cycles so set can mature.
      for (int seg = 0; seg < 300; seg++) begin
         int hold;
         @(posedge clk);
         #1;
         rst = ($urandom_range(0, 39) == 0);
         drive($urandom_range(0, 1) == 1,
               $urandom_range(0, 5) != 0,
               $urandom_range(0, 7) != 0,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 7) == 0);
         if (rst) begin
            @(posedge clk);
            #1 rst = 1'b0;
         end
         hold = $urandom_range(1, 12);
         repeat (hold) @(posedge clk);
      end

      @(posedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_on_off_logic

// File: doc/on_off_logic.md
Name: on_off_logic

Overview:
Start/stop decision block for the microwave oven controller. It samples the operator buttons (active-low), the door switch and the timer-done flag. From these it produces registered set and reset commands for the magnetron on/off latch, and also holds that latch internally as mag_on. It sits between the keypad/door inputs and the magnetron drive and timer-enable logic.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on every input (0 allowed = no synchronizer, inputs used directly).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
startn  input  1  start button, active-low
stopn  input  1  stop button, active-low
clrn  input  1  clear button, active-low
door_closed  input  1  1 = door closed
timer_done  input  1  1 = cook timer expired
set  output  1  registered set command for the on/off latch
reset  output  1  registered reset command for the on/off latch
mag_on  output  1  magnetron-enable latch state

Behaviour:
- Reset: one clock; rst is synchronous and active-high. While rst=1 at a rising edge:
  - set=0, reset=1, mag_on=0.
  - Synchronizer flops load their safe levels: startn=1, stopn=1, clrn=1, door_closed=0, timer_done=0.
- Input path: each input passes through a SYNC_STAGES-deep flop chain. The synchronized values are called s_*.
- Combinational terms from the synchronized inputs:
  - set_c = !s_startn & s_door_closed & !s_timer_done.
  - reset_c = !s_door_closed | !s_clrn | !s_stopn | s_timer_done.
- Output registers: set <= set_c and reset <= reset_c on every edge.
- Latency: SYNC_STAGES+1 cycles from an input change to set/reset. Default is 3 cycles.
- set and reset may both be 1, e.g. start and stop pressed together with the door closed. Both outputs report their terms independently and are never masked.
- mag_on latch, updated every edge from the registered set/reset:
  - reset=1 → mag_on <= 0. Reset dominates when both are 1.
  - set=1 and reset=0 → mag_on <= 1.
  - Otherwise mag_on holds.
  - mag_on therefore lags set/reset by 1 cycle.
- Door open forces reset=1 regardless of the other inputs. An open door never yields set=1.
- timer_done=1 forces set=0 and reset=1.
- Releasing start (startn back to 1) with no reset condition gives set=0, reset=0, and mag_on holds 1.
- rst asserted mid-operation clears mag_on on that edge and restarts the synchronizer pipeline. After rst is released, reset stays 1 until the door-closed level has propagated.
- No X propagation: all flops have defined reset values.

Decomposition:
- Shared package oven_pkg holds:
  - constant OVEN_SYNC_STAGES_DEFAULT = 2
  - the safe input levels used by the synchronizer reset (BTN_IDLE = 1'b1, DOOR_SAFE = 1'b0, TIMER_SAFE = 1'b0)
- One sub-module is natural: oven_sync.
  - Parameterised-depth single-bit synchronizer with a reset value parameter.
  - Instantiated five times.
- The decode terms and the mag_on latch stay in on_off_logic.

Test Plan:
Each response is checked SYNC_STAGES+1 cycles after the stimulus is applied; mag_on is checked 1 cycle after that.
- rst=1 for 2 cycles, then startn=0, door_closed=1, timer_done=0, stopn=1, clrn=1 → set=1, reset=0; mag_on=1 one cycle later.
- From the on state, apply startn=1, door_closed=1, timer_done=0, stopn=1, clrn=1 → set=0, reset=0, mag_on stays 1.
- startn=0, door_closed=0, timer_done=1, stopn=1, clrn=0 → set=0, reset=1, mag_on=0.
- startn=0, door_closed=1, timer_done=0, stopn=0, clrn=1 → set=1 and reset=1 simultaneously; mag_on=0 (reset wins).
- startn=0, door_closed=1, timer_done=1, stopn=1, clrn=1 → set=0, reset=1. Repeat with startn=1, door_closed=1, stopn=1, clrn=0, timer_done=0 → set=0, reset=1.
- With mag_on=1, assert rst for one cycle → on that edge set=0, reset=1, mag_on=0. After release with door_closed=1 and no buttons pressed, reset=0 after SYNC_STAGES+1 cycles and mag_on stays 0.
